frame_trailer_inserter: RTL and testbench

FRAME_TRAILER_INSERTER -- requirements
Module: frame_trailer_inserter

---
 rtl/frame_trailer_inserter.sv | 130 +++++++++++++
 tb/tb_frame_trailer_inserter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_trailer_inserter.sv
// Frame trailer inserter: passes FRAME_BEATS payload beats, then META_BEATS metadata beats,
// then an optional sequence-number beat, as a zero-latency mux with no data storage.
//
// state   | meaning
// --------+------------------------------------------------
// ST_DATA | forwarding payload beats from s_data
// ST_META | forwarding metadata beats from s_meta
// ST_SEQ  | emitting frame_count as the closing beat
module frame_trailer_inserter #(
    parameter int DW          = 128,
    parameter int FRAME_BEATS = 128,
    parameter int META_BEATS  = 1,
    parameter int SEQ_EN      = 1,
    parameter int SEQ_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     s_data_tdata,
    input  logic              s_data_tvalid,
    output logic              s_data_tready,
    input  logic [DW-1:0]     s_meta_tdata,
    input  logic              s_meta_tvalid,
    output logic              s_meta_tready,
    output logic [DW-1:0]     m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [DW/8-1:0]   m_tkeep,
    output logic [1:0]        fsm_state,
    output logic [SEQ_W-1:0]  frame_count
);

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_META = 2'd1,
        ST_SEQ  = 2'd2
    } state_t;

    localparam logic [15:0] BEAT_LAST = 16'(FRAME_BEATS - 1);
    localparam logic [3:0]  META_LAST = 4'(META_BEATS - 1);
    localparam state_t AFTER_DATA = (META_BEATS > 0) ? ST_META :
                                    ((SEQ_EN != 0) ? ST_SEQ : ST_DATA);
    localparam state_t AFTER_META = (SEQ_EN != 0) ? ST_SEQ : ST_DATA;

    state_t            state, state_nxt;
    logic [15:0]       beat_cnt, beat_cnt_nxt;
    logic [3:0]        meta_cnt, meta_cnt_nxt;
    logic [SEQ_W-1:0]  frame_count_nxt;
    logic              beat_last, meta_last;

    assign beat_last = (beat_cnt == BEAT_LAST);
    assign meta_last = (meta_cnt == META_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_DATA;
            beat_cnt    <= '0;
            meta_cnt    <= '0;
            frame_count <= '0;
        end else begin
            state       <= state_nxt;
            beat_cnt    <= beat_cnt_nxt;
            meta_cnt    <= meta_cnt_nxt;
            frame_count <= frame_count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        beat_cnt_nxt    = beat_cnt;
        meta_cnt_nxt    = meta_cnt;
        frame_count_nxt = frame_count;
        m_tdata         = '0;
        m_tvalid        = 1'b0;
        m_tlast         = 1'b0;
        s_data_tready   = 1'b0;
        s_meta_tready   = 1'b0;

        case (state)
            ST_DATA: begin
                m_tdata       = s_data_tdata;
                m_tvalid      = s_data_tvalid;
                s_data_tready = m_tready;
                m_tlast       = s_data_tvalid && beat_last && (AFTER_DATA == ST_DATA);
                if (s_data_tvalid && m_tready) begin
                    if (beat_last) begin
                        beat_cnt_nxt = '0;
                        state_nxt    = AFTER_DATA;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 16'd1;
                    end
                end
            end
            ST_META: begin
                m_tdata       = s_meta_tdata;
                m_tvalid      = s_meta_tvalid;
                s_meta_tready = m_tready;
                m_tlast       = s_meta_tvalid && meta_last && (AFTER_META == ST_DATA);
                if (s_meta_tvalid && m_tready) begin
                    if (meta_last) begin
                        meta_cnt_nxt = '0;
                        state_nxt    = AFTER_META;
                    end else begin
                        meta_cnt_nxt = meta_cnt + 4'd1;
                    end
                end
            end
            ST_SEQ: begin
                m_tdata[SEQ_W-1:0] = frame_count;
                m_tvalid           = 1'b1;
                m_tlast            = 1'b1;
                if (m_tready) begin
                    state_nxt = ST_DATA;
                end
            end
            default: begin
                state_nxt = ST_DATA;
            end
        endcase

        // the frame number advances on whichever beat closes the frame
        if (m_tvalid && m_tready && m_tlast) begin
            frame_count_nxt = frame_count + 1'b1;
        end
    end

    assign m_tkeep   = m_tvalid ? '1 : '0;
    assign fsm_state = state;

endmodule

// File: tb/tb_frame_trailer_inserter.sv
// Directed bench for frame_trailer_inserter: three instances cover the default-style
// framing with throttling and reset, a narrow wrapping sequence counter, and payload-only frames.
module tb_frame_trailer_inserter;

    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // instance A: FRAME_BEATS=4, META_BEATS=1, SEQ_EN=1, SEQ_W=32
    logic [DW-1:0] a_s_data_tdata, a_s_meta_tdata, a_m_tdata;
    logic          a_s_data_tvalid, a_s_data_tready, a_s_meta_tvalid, a_s_meta_tready;
    logic          a_m_tvalid, a_m_tready, a_m_tlast;
    logic [7:0]    a_m_tkeep;
    logic [1:0]    a_fsm_state;
    logic [31:0]   a_frame_count;

    // instance B: FRAME_BEATS=2, META_BEATS=1, SEQ_EN=1, SEQ_W=4
    logic [DW-1:0] b_s_data_tdata, b_s_meta_tdata, b_m_tdata;
    logic          b_s_data_tvalid, b_s_data_tready, b_s_meta_tvalid, b_s_meta_tready;
    logic          b_m_tvalid, b_m_tready, b_m_tlast;
    logic [7:0]    b_m_tkeep;
    logic [1:0]    b_fsm_state;
    logic [3:0]    b_frame_count;

    // instance C: FRAME_BEATS=3, META_BEATS=0, SEQ_EN=0, SEQ_W=8
    logic [DW-1:0] c_s_data_tdata, c_s_meta_tdata, c_m_tdata;
    logic          c_s_data_tvalid, c_s_data_tready, c_s_meta_tvalid, c_s_meta_tready;
    logic          c_m_tvalid, c_m_tready, c_m_tlast;
    logic [7:0]    c_m_tkeep;
    logic [1:0]    c_fsm_state;
    logic [7:0]    c_frame_count;

    frame_trailer_inserter #(.DW(DW), .FRAME_BEATS(4), .META_BEATS(1), .SEQ_EN(1), .SEQ_W(32)) u_a (
        .clk(clk), .reset(reset),
        .s_data_tdata(a_s_data_tdata), .s_data_tvalid(a_s_data_tvalid), .s_data_tready(a_s_data_tready),
        .s_meta_tdata(a_s_meta_tdata), .s_meta_tvalid(a_s_meta_tvalid), .s_meta_tready(a_s_meta_tready),
        .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(a_m_tready), .m_tlast(a_m_tlast),
        .m_tkeep(a_m_tkeep), .fsm_state(a_fsm_state), .frame_count(a_frame_count)
    );

    frame_trailer_inserter #(.DW(DW), .FRAME_BEATS(2), .META_BEATS(1), .SEQ_EN(1), .SEQ_W(4)) u_b (
        .clk(clk), .reset(reset),
        .s_data_tdata(b_s_data_tdata), .s_data_tvalid(b_s_data_tvalid), .s_data_tready(b_s_data_tready),
        .s_meta_tdata(b_s_meta_tdata), .s_meta_tvalid(b_s_meta_tvalid), .s_meta_tready(b_s_meta_tready),
        .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tlast(b_m_tlast),
        .m_tkeep(b_m_tkeep), .fsm_state(b_fsm_state), .frame_count(b_frame_count)
    );

    frame_trailer_inserter #(.DW(DW), .FRAME_BEATS(3), .META_BEATS(0), .SEQ_EN(0), .SEQ_W(8)) u_c (
        .clk(clk), .reset(reset),
        .s_data_tdata(c_s_data_tdata), .s_data_tvalid(c_s_data_tvalid), .s_data_tready(c_s_data_tready),
        .s_meta_tdata(c_s_meta_tdata), .s_meta_tvalid(c_s_meta_tvalid), .s_meta_tready(c_s_meta_tready),
        .m_tdata(c_m_tdata), .m_tvalid(c_m_tvalid), .m_tready(c_m_tready), .m_tlast(c_m_tlast),
        .m_tkeep(c_m_tkeep), .fsm_state(c_fsm_state), .frame_count(c_frame_count)
    );

    int n_chk = 0;
    int n_err = 0;

    // instance A model: position within the 6-beat frame, frame number, next source indices
    int a_pos = 0, a_frame = 0, a_didx = 0, a_midx = 0;
    int b_pos = 0, b_frame = 0, b_didx = 0;
    int c_pos = 0, c_didx = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] dword(input int i);
        return {16'hDA7A, 48'(i)};
    endfunction

    function automatic logic [63:0] mword(input int i);
        return {16'hEE7A, 48'(i)};
    endfunction

    task automatic cycle_a(input logic rdy, input logic dv, input logic mv);
        logic [1:0] exp_st;
        logic       exp_v, exp_dr, exp_mr;
        @(negedge clk);
        a_m_tready      = rdy;
        a_s_data_tvalid = dv;
        a_s_meta_tvalid = mv;
        a_s_data_tdata  = dword(a_didx);
        a_s_meta_tdata  = mword(a_midx);
        #1;
        exp_st = (a_pos < 4) ? 2'd0 : ((a_pos == 4) ? 2'd1 : 2'd2);
        exp_v  = (a_pos < 4) ? dv : ((a_pos == 4) ? mv : 1'b1);
        exp_dr = (a_pos < 4) ? rdy : 1'b0;
        exp_mr = (a_pos == 4) ? rdy : 1'b0;
        check_val("a_state", 64'(a_fsm_state), 64'(exp_st));
        check_val("a_frame_count", 64'(a_frame_count), 64'(a_frame));
        check_val("a_tvalid", 64'(a_m_tvalid), 64'(exp_v));
        check_val("a_data_tready", 64'(a_s_data_tready), 64'(exp_dr));
        check_val("a_meta_tready", 64'(a_s_meta_tready), 64'(exp_mr));
        check_val("a_tkeep", 64'(a_m_tkeep), exp_v ? 64'hFF : 64'h0);
        if (exp_v && rdy) begin
            if (a_pos < 4) begin
                check_val("a_payload", a_m_tdata, dword(a_didx));
                a_didx++;
            end else if (a_pos == 4) begin
                check_val("a_meta", a_m_tdata, mword(a_midx));
                a_midx++;
            end else begin
                check_val("a_seq", a_m_tdata, 64'(a_frame));
            end
            check_val("a_tlast", 64'(a_m_tlast), 64'(a_pos == 5));
            a_pos++;
            if (a_pos == 6) begin
                a_pos = 0;
                a_frame++;
            end
        end
    endtask

    task automatic do_reset(input logic rdy, input logic dv, input logic mv);
        @(negedge clk);
        reset           = 1'b1;
        a_m_tready      = rdy;
        a_s_data_tvalid = dv;
        a_s_meta_tvalid = mv;
        a_s_data_tdata  = dword(a_didx);
        a_s_meta_tdata  = mword(a_midx);
        // the source still sees its handshake on the reset edge, so that beat is gone
        if (a_pos < 4 && dv && rdy) a_didx++;
        if (a_pos == 4 && mv && rdy) a_midx++;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        a_pos   = 0;
        a_frame = 0;
        check_val("rst_state", 64'(a_fsm_state), 64'd0);
        check_val("rst_frame_count", 64'(a_frame_count), 64'd0);
        check_val("rst_data_tready", 64'(a_s_data_tready), 64'(rdy));
        check_val("rst_meta_tready", 64'(a_s_meta_tready), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        a_s_data_tdata = '0; a_s_meta_tdata = '0; a_s_data_tvalid = 0; a_s_meta_tvalid = 0; a_m_tready = 0;
        b_s_data_tdata = '0; b_s_meta_tdata = '0; b_s_data_tvalid = 0; b_s_meta_tvalid = 0; b_m_tready = 0;
        c_s_data_tdata = '0; c_s_meta_tdata = '0; c_s_data_tvalid = 0; c_s_meta_tvalid = 0; c_m_tready = 0;

        do_reset(1'b0, 1'b0, 1'b0);

        // two back-to-back frames, everything ready
        for (int i = 0; i < 12; i++) cycle_a(1'b1, 1'b1, 1'b1);

        // meta valid held through DATA with a throttled sink
        for (int i = 0; i < 20; i++) cycle_a(1'(i % 2), 1'b1, 1'b1);

        // reset while sitting in META with the sink ready
        do_reset(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle_a(1'b1, 1'b1, 1'b0);
        cycle_a(1'b1, 1'b0, 1'b0);
        check_val("s5_in_meta", 64'(a_fsm_state), 64'd1);
        do_reset(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle_a(1'b1, 1'b1, 1'b1);

        // 100 frames under random throttling on all three handshakes
        do_reset(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5000 && a_frame < 100; i++) begin
            cycle_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 3) != 0));
        end
        @(negedge clk);
        a_m_tready = 1'b0;
        #1;
        check_val("s2_frames_done", 64'(a_frame_count), 64'd100);

        // narrow counter wrap on B and payload-only frames on C, run side by side
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            b_m_tready      = 1'b1;
            b_s_data_tvalid = 1'b1;
            b_s_meta_tvalid = 1'b1;
            b_s_data_tdata  = dword(b_didx);
            b_s_meta_tdata  = mword(b_frame);
            c_m_tready      = 1'($urandom_range(0, 1));
            c_s_data_tvalid = 1'($urandom_range(0, 3) != 0);
            c_s_meta_tvalid = 1'b1;
            c_s_data_tdata  = dword(c_didx);
            #1;
            check_val("b_frame_count", 64'(b_frame_count), 64'(b_frame % 16));
            check_val("b_tvalid", 64'(b_m_tvalid), 64'd1);
            if (b_pos == 3) begin
                check_val("b_seq", b_m_tdata, 64'(b_frame % 16));
            end else if (b_pos < 2) begin
                check_val("b_payload", b_m_tdata, dword(b_didx));
                b_didx++;
            end
            check_val("b_tlast", 64'(b_m_tlast), 64'(b_pos == 3));
            b_pos++;
            if (b_pos == 4) begin
                b_pos = 0;
                b_frame++;
            end

            check_val("c_meta_tready", 64'(c_s_meta_tready), 64'd0);
            check_val("c_state", 64'(c_fsm_state), 64'd0);
            if (c_s_data_tvalid && c_m_tready) begin
                check_val("c_payload", c_m_tdata, dword(c_didx));
                check_val("c_tlast", 64'(c_m_tlast), 64'(c_pos == 2));
                c_didx++;
                c_pos = (c_pos + 1) % 3;
            end
        end
        check_val("b_wrap_seen", 64'(b_frame >= 17), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
